// File: rtl/wallace_pkg.sv
// Shared constants and elaboration helpers for the Wallace multiplier final-adder pipeline.
package wallace_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder; one instance resolves one pipeline slice.
module chunk_adder
  import wallace_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[CHUNK];
  end

endmodule

// File: rtl/wallace_final_adder_pipe.sv
// Carry-propagate stage of the Wallace multiplier: resolves the sum/carry pair CHUNK bits per cycle.
module wallace_final_adder_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
    $error("wallace_final_adder_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  // word_q holds resolved result bits below the stage's chunk and raw sum bits above it.
  logic [WIDTH-1:0]  word_q  [STAGES];
  logic [WIDTH-1:0]  carry_q [STAGES];
  logic              cout_q  [STAGES];
  logic [STAGES-1:0] valid_q;

  logic [WIDTH-1:0]  stage_word  [STAGES];
  logic [WIDTH-1:0]  stage_carry [STAGES];
  logic              stage_cin   [STAGES];
  logic [WIDTH-1:0]  word_nxt    [STAGES];
  logic              cout_nxt    [STAGES];

  logic en;

  assign en       = ~valid_q[STAGES-1] | out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] chunk_s;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_head
      assign stage_word[k]  = in_sum;
      assign stage_carry[k] = in_carry;
      assign stage_cin[k]   = 1'b0;
    end else begin : g_body
      assign stage_word[k]  = word_q[k-1];
      assign stage_carry[k] = carry_q[k-1];
      assign stage_cin[k]   = cout_q[k-1];
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a    (stage_word[k][k*CHUNK +: CHUNK]),
      .b    (stage_carry[k][k*CHUNK +: CHUNK]),
      .cin  (stage_cin[k]),
      .s    (chunk_s),
      .cout (cout_nxt[k])
    );

    always_comb begin
      merged                     = stage_word[k];
      merged[k*CHUNK +: CHUNK]   = chunk_s;
    end

    assign word_nxt[k] = merged;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are cleared too, so a reset leaves no stale operand visible on out_result.
      for (int k = 0; k < STAGES; k++) begin
        word_q[k]  <= '0;
        carry_q[k] <= '0;
        cout_q[k]  <= 1'b0;
      end
      valid_q <= '0;
    end else if (en) begin
      // Bubbles shift with the data; a stage's contents are ignored while its valid bit is low.
      for (int k = 0; k < STAGES; k++) begin
        word_q[k]  <= word_nxt[k];
        carry_q[k] <= stage_carry[k];
        cout_q[k]  <= cout_nxt[k];
      end
      valid_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  assign out_valid  = valid_q[STAGES-1];
  assign out_result = word_q[STAGES-1];
  assign out_cout   = cout_q[STAGES-1];

endmodule

// File: tb/tb_wallace_final_adder_pipe.sv
// Scoreboard bench for wallace_final_adder_pipe: expected 17-bit sums queued at input transfer, popped at output transfer.
module tb_wallace_final_adder_pipe;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum    = '0;
  logic [WIDTH-1:0] in_carry  = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;

  wallace_final_adder_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout)
  );

  always #5 clk = ~clk;

  logic [WIDTH:0] exp_q [$];
  logic [WIDTH:0] mon_exp;
  int checks = 0;
  int errors = 0;
  int n_in   = 0;
  int n_out  = 0;
  int n_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the result is simply the 17-bit unsigned sum of the two vectors.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back({1'b0, in_sum} + {1'b0, in_carry});
      n_in++;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got %h with no item outstanding", {out_cout, out_result});
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard_result", 32'({out_cout, out_result}), 32'(mon_exp));
      end
    end
  end

  task automatic reset_dut();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    n_drop  += exp_q.size();
    exp_q.delete();
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int guard = 0;
    in_valid = 1'b1;
    in_sum   = a;
    in_carry = b;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) check("send_timeout", 32'(guard), 32'(0));
    step();
  endtask

  task automatic wait_out();
    int guard = 0;
    while (!out_valid && guard < 100) begin
      step();
      guard++;
    end
    check("out_valid_wait", 32'(out_valid), 32'(1));
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 500) begin
      step();
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic single(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH:0] exp);
    send(a, b);
    in_valid = 1'b0;
    wait_out();
    check(name, 32'({out_cout, out_result}), 32'(exp));
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    int n_before;
    int target;
    int cyc;
    logic [WIDTH:0] t3_exp [4];
    logic [WIDTH:0] held;

    repeat (2) step();
    reset_dut();
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_out_result", 32'(out_result), 32'(0));
    check("reset_out_cout", 32'(out_cout), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));

    // Full-width carry ripple and exact latency
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'(STAGES));
    check("t1_result", 32'(out_result), 32'h0000);
    check("t1_cout", 32'(out_cout), 32'(1));
    drain();

    // Carries crossing one and three chunk boundaries
    single("t2_chunk1", 16'h000F, 16'h0001, 17'h00010);
    single("t2_chunk3", 16'h0FFF, 16'h0001, 17'h01000);

    // Back-to-back stream, outputs on consecutive cycles
    t3_exp[0] = 17'h00003;
    t3_exp[1] = 17'h10000;
    t3_exp[2] = 17'h05555;
    t3_exp[3] = 17'h1FFFE;
    out_ready = 1'b1;
    send(16'h0001, 16'h0002);
    send(16'h8000, 16'h8000);
    send(16'h1234, 16'h4321);
    send(16'hFFFF, 16'hFFFF);
    in_valid = 1'b0;
    wait_out();
    for (int i = 0; i < 4; i++) begin
      check("t3_valid", 32'(out_valid), 32'(1));
      check("t3_result", 32'({out_cout, out_result}), 32'(t3_exp[i]));
      step();
    end
    drain();

    // Backpressure: output held stable and input stalled
    out_ready = 1'b0;
    send(16'h00FF, 16'h0F01);
    send(16'hABCD, 16'h1111);
    send(16'hF0F0, 16'h0F10);
    in_valid = 1'b0;
    wait_out();
    held = {out_cout, out_result};
    check("t4_first", 32'(held), 32'h00FF + 32'h0F01);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_valid", 32'(out_valid), 32'(1));
      check("t4_hold_data", 32'({out_cout, out_result}), 32'(held));
      check("t4_in_ready", 32'(in_ready), 32'(0));
    end
    drain();

    // Reset with three items in flight
    out_ready = 1'b1;
    send(16'h1111, 16'h2222);
    send(16'h3333, 16'h4444);
    send(16'h5555, 16'h6666);
    in_valid = 1'b0;
    n_before = n_out;
    reset_dut();
    check("t5_out_valid", 32'(out_valid), 32'(0));
    check("t5_out_result", 32'(out_result), 32'(0));
    check("t5_in_ready", 32'(in_ready), 32'(1));
    repeat (10) step();
    check("t5_no_stale", 32'(n_out), 32'(n_before));

    // Random traffic with random backpressure
    target = n_in + 10000;
    cyc = 0;
    while (n_in < target && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sum    = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
      in_carry  = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    check("t6_accepted", 32'(n_in), 32'(target));
    in_valid = 1'b0;
    drain();
    check("count_balance", 32'(n_in), 32'(n_out + n_drop));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
